// File: rtl/test_hu_pkg.sv
// Shared constants and helpers for the Hu-moment datapath blocks.
// Operand width default, multiplier latency, and a constant-foldable log2.
package test_hu_pkg;

  localparam int HU_DATA_W = 16;
  localparam int MUL_LAT   = 3;

  // Number of bits needed to encode values 0 .. value-1 (at least 1).
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      bits = bits + 1;
    end
    if (bits == 0) begin
      bits = 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/test_hu_rr_arbiter.sv
// Parameterised round-robin grant: scans i_valid from i_ptr upwards, wrapping,
// and returns the first set position as a one-hot grant and a binary index.
module test_hu_rr_arbiter
  import test_hu_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = clog2(N)
) (
  input  logic [N-1:0]    i_valid,
  input  logic [ID_W-1:0] i_ptr,
  output logic [N-1:0]    o_grant,
  output logic [ID_W-1:0] o_grant_id,
  output logic            o_any
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [ID_W:0]  w_sum;
  logic           w_found;

  // Rotating a doubled copy right by the pointer puts the pointer position at bit 0.
  assign w_dbl = {i_valid, i_valid} >> i_ptr;
  assign w_rot = w_dbl[N-1:0];

  // NOTE: every variable written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_found    = 1'b0;
    w_sum      = '0;
    o_grant_id = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = (ID_W+1)'(i_ptr) + (ID_W+1)'(k);
        if (w_sum >= (ID_W+1)'(N)) begin
          w_sum = w_sum - (ID_W+1)'(N);
        end
        o_grant_id = w_sum[ID_W-1:0];
      end
    end
  end

  assign o_any   = w_found;
  assign o_grant = w_found ? (N'(1) << o_grant_id) : '0;

endmodule

// File: rtl/test_hu_mul_arbiter.sv
// Shares one pipelined unsigned multiplier among NUM_REQ requesters; a {vld,id}
// shadow pipeline routes each product back to its issuer, response stalls freeze all.
module test_hu_mul_arbiter
  import test_hu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = HU_DATA_W,
  parameter int LAT     = MUL_LAT,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [2*DATA_W-1:0]       rsp_data,
  output logic                      mul_ce,
  output logic [DATA_W-1:0]         mul_din0,
  output logic [DATA_W-1:0]         mul_din1,
  input  logic [2*DATA_W-1:0]       mul_dout,
  output logic                      busy
);

  logic [LAT-1:0]     r_vld;
  logic [ID_W-1:0]    r_id [LAT];
  logic [ID_W-1:0]    r_rr_ptr;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic [ID_W-1:0]    w_ptr_next;
  logic [ID_W-1:0]    w_out_id;
  logic               w_any_valid;
  logic               w_out_vld;
  logic               w_stall;
  logic               w_issue;
  logic [DATA_W-1:0]  w_a [NUM_REQ];
  logic [DATA_W-1:0]  w_b [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_a[gi] = req_a[gi*DATA_W +: DATA_W];
    assign w_b[gi] = req_b[gi*DATA_W +: DATA_W];
  end

  test_hu_rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr_arbiter (
    .i_valid    (req_valid),
    .i_ptr      (r_rr_ptr),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id),
    .o_any      (w_any_valid)
  );

  // The last shadow stage lines up with mul_dout; a refused product freezes everything.
  assign w_out_vld = r_vld[LAT-1];
  assign w_out_id  = r_id[LAT-1];
  assign w_stall   = w_out_vld && !rsp_ready[w_out_id];
  assign mul_ce    = !w_stall;

  assign req_ready = (w_any_valid && mul_ce) ? w_grant : '0;
  assign w_issue   = |(req_valid & req_ready);
  assign mul_din0  = w_a[w_grant_id];
  assign mul_din1  = w_b[w_grant_id];

  assign rsp_valid = w_out_vld ? (NUM_REQ'(1) << w_out_id) : '0;
  assign rsp_data  = mul_dout;
  assign busy      = |r_vld;

  assign w_ptr_next = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its predecessor's pre-edge value and the shift happens as one step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
      r_vld    <= '0;
      // NOTE: the id shadow is a small register array, not RAM, so it is
      // reset too; this keeps the rsp_valid decode free of unknowns.
      for (int i = 0; i < LAT; i++) begin
        r_id[i] <= '0;
      end
    end else begin
      if (w_issue) begin
        r_rr_ptr <= w_ptr_next;
      end
      if (mul_ce) begin
        r_vld[0] <= w_issue;
        r_id[0]  <= w_grant_id;
        for (int i = 1; i < LAT; i++) begin
          r_vld[i] <= r_vld[i-1];
          r_id[i]  <= r_id[i-1];
        end
      end
    end
  end

endmodule

// File: doc/test_hu_mul_arbiter.md
# test_hu_mul_arbiter

Round-robin arbiter that shares one pipelined 16x16 unsigned multiplier (the `test_Hu_mul_mul_16ns_16ns_32_4_1` instance) among NUM_REQ requesters in the Hu-moment datapath. It accepts operand pairs over valid/ready handshakes and issues at most one product per cycle into the multiplier. It tracks each in-flight operation's owner in a valid/ID shadow pipeline and routes every 32-bit product back to the requester that issued it. Response backpressure stalls the whole multiplier through its `ce` input, so no product is ever dropped.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 16: operand width; product width is 2*DATA_W.
- LAT, 3: cycles from operands on `mul_din0`/`mul_din1` with `mul_ce`=1 to the product on `mul_dout`, counting `ce`-enabled cycles only.
- ID_W, clog2(NUM_REQ): owner-ID width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low. Asserting (0) clears all state immediately; deassertion must be synchronous to `clk` upstream.
- req_valid  in  NUM_REQ  requester i has an operand pair.
- req_ready  out  NUM_REQ  one-hot or zero; pair from i accepted this cycle.
- req_a  in  NUM_REQ*DATA_W  flattened operand A, slice i = [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  flattened operand B.
- rsp_valid  out  NUM_REQ  one-hot or zero; product for requester i present.
- rsp_ready  in  NUM_REQ  requester i takes its product.
- rsp_data  out  2*DATA_W  shared product bus, valid for whichever `rsp_valid` bit is set.
- mul_ce  out  1  multiplier clock enable.
- mul_din0  out  DATA_W  to multiplier `din0`.
- mul_din1  out  DATA_W  to multiplier `din1`.
- mul_dout  in  2*DATA_W  from multiplier `dout`.
- busy  out  1  high while any operation is in flight.

## Operation
- Shadow pipeline: LAT stages of {vld, id}, advancing only when `mul_ce`=1. Stage 0 loads {issue, grant_id}; stage LAT-1 aligns with `mul_dout`.
- Output stage: out_vld = vld[LAT-1], out_id = id[LAT-1].
- `rsp_valid[i]` = out_vld && out_id==i. `rsp_data` = `mul_dout` (unmasked).
- Stall: stall = out_vld && !rsp_ready[out_id]; `mul_ce` = !stall. The multiplier and shadow pipeline freeze together.
- Arbitration (combinational): scan `req_valid` starting at pointer `rr_ptr`, wrapping modulo NUM_REQ. The first set bit is grant_id.
- `req_ready[grant_id]` = any(req_valid) && `mul_ce`; all other bits are 0. issue = any bit of (req_valid & req_ready).
- `mul_din0`/`mul_din1` = req_a/req_b slice of grant_id whenever `mul_ce`=1; their value is don't-care when no issue occurs.
- Pointer update: on issue, `rr_ptr` <= (grant_id+1) mod NUM_REQ. Otherwise unchanged, including during a stall.
- Requesters hold `req_valid` and their operands until accepted. The arbiter never retracts `req_ready` within a cycle.
- Arithmetic: unsigned, full 2*DATA_W product, no truncation or saturation.
- busy = OR of all vld stages.

## Timing
- Reset values: rr_ptr=0, all vld=0, id=0. Outputs: req_ready=0, rsp_valid=0, mul_ce=1, busy=0.
- Latency: a pair accepted in cycle t appears as a response at cycle t+LAT when there are no stalls. Each stall cycle adds one.
- Throughput: one issue per cycle. Back-to-back operations from the same or different requesters are supported.
- Simultaneous events:
  - Issue and response retire in the same cycle: both occur.
  - A response held by a requester blocks every requester's issue. This is deliberate, because the pipeline is in order.
- Single requester: it is granted every cycle (pointer wraps back to itself).
- Reset mid-operation: in-flight products are discarded and no `rsp_valid` is raised afterwards. The multiplier has no reset; its stale contents are masked because vld=0.
- Ordering: responses return in issue order. Per requester, order is preserved.

## Structure
- Shared package `test_hu_pkg`: DATA_W default, MUL_LAT=3, clog2 function.
- Sub-module `test_hu_rr_arbiter`: a parameterised round-robin grant (valid vector, pointer -> one-hot grant, grant_id). It is reused elsewhere in the design.
- The multiplier is instantiated outside this block. Wire `mul_ce`→`ce`, `mul_din0`→`din0`, `mul_din1`→`din1`, `mul_dout`←`dout`, and drive its `reset` from the inverted system reset.

## Test plan
- Single op: req 0 sends a=3, b=5; `rsp_ready`=all 1 → `rsp_valid[0]` exactly 3 cycles after acceptance, `rsp_data`=15.
- All four requesters valid continuously with a=i+1, b=100 → grants in order 0,1,2,3,0,…, one per cycle. Products 100,200,300,400 return to owners 0..3 in order.
- Max operands: a=b=16'hFFFF → `rsp_data`=32'hFFFE0001, with no truncation.
- Backpressure: `rsp_ready[1]`=0 for 5 cycles while its product is at the output → `mul_ce`=0, `req_ready`=0 and `rsp_data` stable for those 5 cycles. The product is delivered once `rsp_ready[1]` rises, and later products are unshifted and correct.
- Fairness: req 0 always valid, req 2 asserts once → req 2 is granted within NUM_REQ cycles.
- Reset with 3 ops in flight → all outputs go to their reset values at once, no `rsp_valid` pulses follow, and `busy`=0.
